// File: rtl/duck_flight_ctrl.sv
// duck_flight_ctrl: single-duck flight controller (launch, edge bounce, flee, shot/hold/fall).
// Optional DUCK_SPEEDUP_EN: every bounce speeds the duck up, saturating at STEP_MAX.
module duck_flight_ctrl #(
  parameter int X_MIN        = 16,
  parameter int X_MAX        = 592,
  parameter int Y_MIN        = 16,
  parameter int GROUND_Y     = 300,
  parameter int STEP_LG      = 4,
  parameter int STEP_SM      = 2,
  parameter int STEP_MAX     = 8,
  parameter int FLEE_TICKS   = 64,
  parameter int HOLD_TICKS   = 5,
  parameter int COLOR_STRIDE = 20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Anim_tick,
  input  logic       Start,
  input  logic [1:0] Color_rand,
  input  logic [1:0] Dir_rand,
  input  logic [9:0] Start_X_rand,
  input  logic       Shot,
  output logic [9:0] Duck_X,
  output logic [9:0] Duck_Y,
  output logic [5:0] DuckFrame,
  output logic [1:0] Duck_color,
  output logic       Active,
  output logic       Done,
  output logic       Hit,
  output logic       Escaped
);

  typedef enum logic [2:0] {IDLE, FLY, SHOT_HOLD, FALL, ESCAPE, DONE} state_t;

  localparam int FW = $clog2(FLEE_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] GND_S  = 11'(GROUND_Y);
  // Steps never exceed the ceiling, even in the fixed-speed build.
  localparam logic signed [10:0] LG_S = 11'((STEP_LG > STEP_MAX) ? STEP_MAX : STEP_LG);
  localparam logic signed [10:0] SM_S = 11'((STEP_SM > STEP_MAX) ? STEP_MAX : STEP_SM);

  state_t          state_q, state_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [5:0]      frame_q, frame_d;
  logic [1:0]      color_q, color_d, dir_q, dir_d, flap_q, flap_d;
  logic            vdown_q, vdown_d, hit_q, hit_d, escaped_q, escaped_d;
  logic [FW-1:0]   flee_cnt_q, flee_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic signed [10:0] dx, dy, xs, ys, nx, ny, sx, fall_y, rise_y;

`ifdef DUCK_SPEEDUP_EN
  logic [9:0] step_lg_q, step_lg_d, step_sm_q, step_sm_d;
  int         bumps;

  function automatic logic [9:0] sat_step(input logic [9:0] s, input int b);
    int t;
    t = int'(s) + b;
    return (t > STEP_MAX) ? 10'(STEP_MAX) : 10'(t);
  endfunction
`endif

  // Frame bases within a colour block: NE 0, E 4, NW 11, W 15.
  function automatic int dir_base(input logic [1:0] d);
    case (d)
      2'b10:   return 0;
      2'b11:   return 4;
      2'b00:   return 11;
      default: return 15;
    endcase
  endfunction

  function automatic logic [5:0] frame_of(input logic [1:0] c, input int base, input logic [1:0] f);
    return 6'(int'(c) * COLOR_STRIDE + base + int'(f));
  endfunction

  function automatic logic [1:0] next_flap(input logic [1:0] f);
    return (f == 2'd2) ? 2'd0 : f + 2'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    frame_d    = frame_q;
    color_d    = color_q;
    dir_d      = dir_q;
    vdown_d    = vdown_q;
    flap_d     = flap_q;
    flee_cnt_d = flee_cnt_q;
    hold_cnt_d = hold_cnt_q;
    hit_d      = hit_q;
    escaped_d  = escaped_q;
`ifdef DUCK_SPEEDUP_EN
    step_lg_d  = step_lg_q;
    step_sm_d  = step_sm_q;
    bumps      = 0;
    dx         = signed'({1'b0, step_lg_q});
    dy         = dir_q[0] ? signed'({1'b0, step_sm_q}) : signed'({1'b0, step_lg_q});
`else
    dx         = LG_S;
    dy         = dir_q[0] ? SM_S : LG_S;
`endif
    xs     = signed'({1'b0, x_q});
    ys     = signed'({1'b0, y_q});
    sx     = signed'({1'b0, Start_X_rand});
    nx     = dir_q[1] ? xs + dx : xs - dx;
    ny     = vdown_q ? ys + dy : ys - dy;
    fall_y = ys + LG_S;
    rise_y = ys - LG_S;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d    = FLY;
          color_d    = (Color_rand == 2'd3) ? 2'd0 : Color_rand;
          dir_d      = Dir_rand;
          if (sx < XMIN_S)      x_d = 10'(X_MIN);
          else if (sx > XMAX_S) x_d = 10'(X_MAX);
          else                  x_d = Start_X_rand;
          y_d        = 10'(GROUND_Y);
          vdown_d    = 1'b0;
          flap_d     = 2'd0;
          flee_cnt_d = '0;
          hit_d      = 1'b0;
          escaped_d  = 1'b0;
          frame_d    = frame_of(color_d, dir_base(Dir_rand), 2'd0);
`ifdef DUCK_SPEEDUP_EN
          step_lg_d  = 10'(STEP_LG);
          step_sm_d  = 10'(STEP_SM);
`endif
        end
      end
      FLY: begin
        // A shot freezes the duck on the spot and beats a coincident flee expiry.
        if (Shot) begin
          state_d    = SHOT_HOLD;
          hold_cnt_d = '0;
        end else if (Anim_tick) begin
          frame_d = frame_of(color_q, dir_base(dir_q), flap_q);
          if (nx < XMIN_S) begin
            x_d      = 10'(X_MIN);
            dir_d[1] = ~dir_q[1];
`ifdef DUCK_SPEEDUP_EN
            bumps    = bumps + 1;
`endif
          end else if (nx > XMAX_S) begin
            x_d      = 10'(X_MAX);
            dir_d[1] = ~dir_q[1];
`ifdef DUCK_SPEEDUP_EN
            bumps    = bumps + 1;
`endif
          end else begin
            x_d = nx[9:0];
          end
          if (ny <= YMIN_S) begin
            y_d     = 10'(Y_MIN);
            vdown_d = 1'b1;
`ifdef DUCK_SPEEDUP_EN
            bumps   = bumps + 1;
`endif
          end else if (ny >= GND_S) begin
            y_d     = 10'(GROUND_Y);
            vdown_d = 1'b0;
`ifdef DUCK_SPEEDUP_EN
            bumps   = bumps + 1;
`endif
          end else begin
            y_d = ny[9:0];
          end
          flap_d     = next_flap(flap_q);
          flee_cnt_d = flee_cnt_q + FW'(1);
          if (flee_cnt_d == FW'(FLEE_TICKS)) state_d = ESCAPE;
`ifdef DUCK_SPEEDUP_EN
          step_lg_d  = sat_step(step_lg_q, bumps);
          step_sm_d  = sat_step(step_sm_q, bumps);
`endif
        end
      end
      SHOT_HOLD: begin
        if (Anim_tick) begin
          frame_d    = frame_of(color_q, 18, 2'd0);
          hold_cnt_d = hold_cnt_q + HW'(1);
          if (hold_cnt_d == HW'(HOLD_TICKS)) begin
            state_d    = FALL;
            hold_cnt_d = '0;
          end
        end
      end
      FALL: begin
        if (Anim_tick) begin
          frame_d = frame_of(color_q, 19, 2'd0);
          if (fall_y >= GND_S) begin
            y_d     = 10'(GROUND_Y);
            hit_d   = 1'b1;
            state_d = DONE;
          end else begin
            y_d = fall_y[9:0];
          end
        end
      end
      ESCAPE: begin
        if (Anim_tick) begin
          frame_d = frame_of(color_q, 8, flap_q);
          flap_d  = next_flap(flap_q);
          if (rise_y <= YMIN_S) begin
            y_d       = 10'(Y_MIN);
            escaped_d = 1'b1;
            state_d   = DONE;
          end else begin
            y_d = rise_y[9:0];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= 10'(GROUND_Y);
      frame_q    <= '0;
      color_q    <= '0;
      dir_q      <= '0;
      vdown_q    <= 1'b0;
      flap_q     <= '0;
      flee_cnt_q <= '0;
      hold_cnt_q <= '0;
      hit_q      <= 1'b0;
      escaped_q  <= 1'b0;
`ifdef DUCK_SPEEDUP_EN
      step_lg_q  <= 10'(STEP_LG);
      step_sm_q  <= 10'(STEP_SM);
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      frame_q    <= frame_d;
      color_q    <= color_d;
      dir_q      <= dir_d;
      vdown_q    <= vdown_d;
      flap_q     <= flap_d;
      flee_cnt_q <= flee_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      hit_q      <= hit_d;
      escaped_q  <= escaped_d;
`ifdef DUCK_SPEEDUP_EN
      step_lg_q  <= step_lg_d;
      step_sm_q  <= step_sm_d;
`endif
    end
  end

  assign Duck_X     = x_q;
  assign Duck_Y     = y_q;
  assign DuckFrame  = frame_q;
  assign Duck_color = color_q;
  assign Active     = (state_q != IDLE) && (state_q != DONE);
  assign Done       = (state_q == DONE);
  assign Hit        = hit_q;
  assign Escaped    = escaped_q;

endmodule

// File: doc/duck_flight_ctrl.md
Name: duck_flight_ctrl

Overview:
- Parametrised single-duck flight controller; successor to the fixed four-direction duck stepping in the dog/duck animation FSM.
- Adds playfield bounds with edge bounce, vertical reversal, a flee timeout, and a shot → hold → fall sequence.
- Runs on Clk and advances only on the one-cycle Anim_tick strobe. Feeds Duck_X/Duck_Y/DuckFrame to the sprite renderer and Done/Hit/Escaped to game logic.

Parameters:
- X_MIN, 16, left bound (pixels)
- X_MAX, 592, right bound (top-left sprite X)
- Y_MIN, 16, top bound
- GROUND_Y, 300, launch Y and fall floor
- STEP_LG, 4, large step per tick
- STEP_SM, 2, small step per tick
- STEP_MAX, 8, step ceiling (optional feature only)
- FLEE_TICKS, 64, FLY ticks before escape
- HOLD_TICKS, 5, ticks frozen after shot
- COLOR_STRIDE, 20, DuckFrame offset per colour

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- Anim_tick  in  1  one-Clk pulse, animation rate
- Start  in  1  launch request; sampled only in IDLE
- Color_rand  in  2  colour at launch; 3 treated as 0
- Dir_rand  in  2  direction at launch. Bit1 = east, bit0 = shallow: 00 NW, 01 W, 10 NE, 11 E
- Start_X_rand  in  10  launch X, clamped to [X_MIN, X_MAX]
- Shot  in  1  hit pulse; honoured only in FLY
- Duck_X  out  10  sprite X
- Duck_Y  out  10  sprite Y
- DuckFrame  out  6  sprite frame index
- Duck_color  out  2  latched colour
- Active  out  1  1 in every state except IDLE and DONE
- Done  out  1  one-cycle pulse at round end
- Hit  out  1  round result: shot
- Escaped  out  1  round result: flew away

Behaviour:
- Reset (synchronous, wins over every other input):
  - state IDLE; Duck_X = 0, Duck_Y = GROUND_Y, DuckFrame = 0, Duck_color = 0.
  - dir = 0, vdown = 0, flap = 0, flee_cnt = 0, hold_cnt = 0.
  - Active, Done, Hit and Escaped all 0.
  - Reset mid-flight aborts immediately; no Done pulse.
- States: IDLE, FLY, SHOT_HOLD, FALL, ESCAPE, DONE. All position, frame and counter updates occur only on Clk edges where Anim_tick=1. State transitions below happen on Clk edges regardless of Anim_tick unless stated.
- IDLE → FLY on Start, same edge. Latch colour and direction; Duck_X = clamped Start_X_rand; Duck_Y = GROUND_Y; vdown = 0; flap = 0; flee_cnt = 0. Clear Hit and Escaped.
- FLY, per tick:
  - dx = STEP_LG in every direction.
  - dy = STEP_LG when bit0 = 0 (steep), STEP_SM when bit0 = 1 (shallow).
  - X moves +dx if east, else −dx. Y moves −dy if !vdown, else +dy.
  - Arithmetic is 11-bit signed, then clamped.
  - X bounce: next X < X_MIN → X = X_MIN and invert dir bit1. next X > X_MAX → X = X_MAX and invert bit1.
  - Y bounce: next Y ≤ Y_MIN → Y = Y_MIN, vdown = 1. next Y ≥ GROUND_Y → Y = GROUND_Y, vdown = 0.
  - A corner hit reverses both axes on the same tick.
  - flap = (flap + 1) mod 3.
  - flee_cnt++; when it reaches FLEE_TICKS → ESCAPE on that tick.
- FLY frame: DuckFrame = color·COLOR_STRIDE + base + flap, where base is NE 0, E 4, NW 11, W 15.
- Shot in FLY → SHOT_HOLD on that edge, with or without a tick. If Shot and the flee expiry coincide, Shot wins.
- SHOT_HOLD: position frozen; DuckFrame = color·COLOR_STRIDE + 18. After HOLD_TICKS ticks → FALL.
- FALL: Y += STEP_LG per tick; DuckFrame = color·COLOR_STRIDE + 19. When Y ≥ GROUND_Y: Y = GROUND_Y, Hit = 1, → DONE.
- ESCAPE: X frozen; Y −= STEP_LG per tick; frame = base 8 + flap. When Y ≤ Y_MIN: Escaped = 1, → DONE.
- DONE: Done = 1 for exactly one Clk, then → IDLE. Hit/Escaped and position hold until the next Start.
- Shot outside FLY and Start outside IDLE are ignored.

Optional Feature:
- Macro: DUCK_SPEEDUP_EN.
- Defined: on each X or Y bounce, STEP_LG_eff and STEP_SM_eff each increment by 1, saturating at STEP_MAX. Both reset to the parameter values on Start.
- Undefined: steps are fixed at STEP_LG / STEP_SM; no speed registers exist.

Test Plan:
- Reset, then Start with Start_X_rand=100, Dir=10 (NE), Color=1; 3 ticks → X=112, Y=288, DuckFrame=22 (20+0+2), Active=1.
- Start_X_rand=590, Dir=11 (E); 1 tick → X=592 (clamped), dir becomes W (01); next tick X=588, DuckFrame=15+flap.
- No Shot, FLEE_TICKS=64 → ESCAPE after tick 64; Y climbs by 4 per tick to 16; Done pulses exactly 1 cycle, Escaped=1, Hit=0.
- Shot at tick 10 with Y=260 → 5 frozen ticks at frame color·20+18. Y then reaches 300 after 10 ticks, Hit=1, Done pulse.
- Shot and flee expiry on the same edge → SHOT_HOLD, Escaped stays 0. Reset asserted in FALL → IDLE next edge, all outputs at reset values, no Done.
- DUCK_SPEEDUP_EN defined: two X bounces → step 6; after four more bounces saturates at 8.
